cpu_serial_alu: RTL and testbench

//  Parametrised, digit-serial successor to the 6502 ALU for wide-word CPU cores.
//  - Ops: COPY/AND/OR/EOR/ADC/SBC/ROR/ROL; binary or BCD. Produces C/Z/N/V.
//  - Arithmetic runs NPC nibbles/cycle, carry registered between digit groups.
//  - Sits between the core's operand latches and register file; valid/ready both sides.

---
 rtl/cpu_serial_alu_pkg.sv | 27 ++
 rtl/cpu_serial_alu_digit.sv | 35 +++
 rtl/cpu_serial_alu.sv | 177 +++++++++++++++++
 tb/tb_cpu_serial_alu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_serial_alu_pkg.sv
// Shared op codes, FSM states and small helpers for the digit-serial ALU.
package cpu_serial_alu_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [2:0] {
    ALU_COPY = 3'd0,
    ALU_AND  = 3'd1,
    ALU_OR   = 3'd2,
    ALU_EOR  = 3'd3,
    ALU_ADC  = 3'd4,
    ALU_SBC  = 3'd5,
    ALU_ROR  = 3'd6,
    ALU_ROL  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_arith(input alu_op_e op);
    return (op == ALU_ADC) || (op == ALU_SBC);
  endfunction

endpackage

// File: rtl/cpu_serial_alu_digit.sv
// One combinational 4-bit binary/BCD add/subtract slice; chained NPC times by the top.
module cpu_serial_alu_digit
  import cpu_serial_alu_pkg::*;
(
  input  logic [NIBBLE-1:0] a_i,
  input  logic [NIBBLE-1:0] b_i,
  input  logic              cin_i,
  input  logic              subtract_i,
  input  logic              decimal_i,
  output logic [NIBBLE-1:0] sum_o,
  output logic              cout_o,
  output logic              raw_top_o
);

  logic [NIBBLE-1:0] b_eff;
  logic [NIBBLE:0]   s_raw;

  always_comb begin
    b_eff     = subtract_i ? ~b_i : b_i;
    s_raw     = {1'b0, a_i} + {1'b0, b_eff} + {{NIBBLE{1'b0}}, cin_i};
    sum_o     = s_raw[NIBBLE-1:0];
    cout_o    = s_raw[NIBBLE];
    raw_top_o = s_raw[NIBBLE-1];
    // Out-of-range BCD nibbles still go through the same correction, no error flag
    if (decimal_i && !subtract_i) begin
      if (s_raw > 5'd9) begin
        sum_o  = s_raw[NIBBLE-1:0] + 4'd6;
        cout_o = 1'b1;
      end
    end else if (decimal_i && !s_raw[NIBBLE]) begin
      sum_o = s_raw[NIBBLE-1:0] + 4'd10;
    end
  end

endmodule

// File: rtl/cpu_serial_alu.sv
// Digit-serial 6502-style ALU: logic/shift ops in one cycle, ADC/SBC over WIDTH/(4*NPC) cycles.
//  state   | meaning
//  IDLE    | in_ready high, waiting for a request
//  RUN     | ADC/SBC digit groups in progress, LSB group first
//  DONE    | result and flags valid, held until out_ready
module cpu_serial_alu
  import cpu_serial_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NPC   = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] operand1_i,
  input  logic [WIDTH-1:0] operand2_i,
  input  logic             carry_in_i,
  input  logic [2:0]       operation_i,
  input  logic             decimal_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             zero_o,
  output logic             negative_o,
  output logic             overflow_o
);

  localparam int GW = NIBBLE * NPC;
  localparam int G  = WIDTH / GW;
  localparam int CW = (G > 1) ? $clog2(G) : 1;

  alu_state_e       state_q;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, dec_q;
  logic             in_ready_q, out_valid_q, carry_q, zero_q, neg_q, ovf_q;

  logic [NPC:0]        c_chain;
  logic [GW-1:0]       grp_sum;
  logic [NPC-1:0]      raw_v;
  logic [WIDTH+GW-1:0] r_cat;
  logic [WIDTH-1:0]    r_next;
  logic                sub, a_top, b_top, ovf_grp;
  logic                lint_unused;

  assign sub        = (op_q == ALU_SBC);
  assign c_chain[0] = c_q;

  for (genvar i = 0; i < NPC; i++) begin : g_digit
    cpu_serial_alu_digit u_digit (
      .a_i        (a_q[NIBBLE*i +: NIBBLE]),
      .b_i        (b_q[NIBBLE*i +: NIBBLE]),
      .cin_i      (c_chain[i]),
      .subtract_i (sub),
      .decimal_i  (dec_q),
      .sum_o      (grp_sum[NIBBLE*i +: NIBBLE]),
      .cout_o     (c_chain[i+1]),
      .raw_top_o  (raw_v[i])
    );
  end

  // Result fills from the top so the final group lands in the MSB nibbles
  assign r_cat  = {grp_sum, r_q};
  assign r_next = r_cat[WIDTH+GW-1:GW];

  // V uses the top nibble's uncorrected sum, valid only on the last group
  assign a_top   = a_q[GW-1];
  assign b_top   = b_q[GW-1] ^ sub;
  assign ovf_grp = ~(a_top ^ b_top) & (a_top ^ raw_v[NPC-1]);

  assign lint_unused = ^{raw_v, r_cat[GW-1:0]};

  logic [WIDTH-1:0] l_res;
  logic             l_c;

  always_comb begin
    l_res = operand1_i;
    l_c   = 1'b0;
    case (alu_op_e'(operation_i))
      ALU_AND: l_res = operand1_i & operand2_i;
      ALU_OR:  l_res = operand1_i | operand2_i;
      ALU_EOR: l_res = operand1_i ^ operand2_i;
      ALU_ROR: begin
        l_res = {carry_in_i, operand1_i[WIDTH-1:1]};
        l_c   = operand1_i[0];
      end
      ALU_ROL: begin
        l_res = {operand1_i[WIDTH-2:0], carry_in_i};
        l_c   = operand1_i[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      op_q        <= ALU_COPY;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      dec_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            in_ready_q <= 1'b0;
            if (is_arith(alu_op_e'(operation_i))) begin
              op_q    <= alu_op_e'(operation_i);
              a_q     <= operand1_i;
              b_q     <= operand2_i;
              c_q     <= carry_in_i;
              dec_q   <= decimal_mode_i;
              r_q     <= '0;
              cnt_q   <= '0;
              state_q <= ST_RUN;
            end else begin
              result_q    <= l_res;
              carry_q     <= l_c;
              zero_q      <= ~|l_res;
              neg_q       <= l_res[WIDTH-1];
              ovf_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          a_q <= a_q >> GW;
          b_q <= b_q >> GW;
          r_q <= r_next;
          c_q <= c_chain[NPC];
          if (cnt_q == CW'(G - 1)) begin
            result_q    <= r_next;
            carry_q     <= c_chain[NPC];
            zero_q      <= ~|r_next;
            neg_q       <= r_next[WIDTH-1];
            ovf_q       <= ovf_grp;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign carry_out_o = carry_q;
  assign zero_o      = zero_q;
  assign negative_o  = neg_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_cpu_serial_alu.sv
// Bench for cpu_serial_alu: directed vectors, random ops vs a nibble-level model, handshake corners.
module tb_cpu_serial_alu;

  localparam logic [2:0] OP_COPY = 3'd0, OP_AND = 3'd1, OP_OR = 3'd2, OP_EOR = 3'd3,
                         OP_ADC = 3'd4, OP_SBC = 3'd5, OP_ROR = 3'd6, OP_ROL = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT0: WIDTH=8, NPC=2 (G=1). DUT1: WIDTH=16, NPC=1 (G=4).
  logic       rst0, iv0, ir0, cin0, dec0, ov0, ordy0, c0, z0, n0, v0;
  logic [2:0] op0;
  logic [7:0] a0, b0, r0;
  logic        rst1, iv1, ir1, cin1, dec1, ov1, ordy1, c1, z1, n1, v1;
  logic [2:0]  op1;
  logic [15:0] a1, b1, r1;

  cpu_serial_alu #(.WIDTH(8), .NPC(2)) u_dut0 (
    .clock_i(clk), .reset_i(rst0), .in_valid_i(iv0), .in_ready_o(ir0),
    .operand1_i(a0), .operand2_i(b0), .carry_in_i(cin0), .operation_i(op0),
    .decimal_mode_i(dec0), .out_valid_o(ov0), .out_ready_i(ordy0), .result_o(r0),
    .carry_out_o(c0), .zero_o(z0), .negative_o(n0), .overflow_o(v0)
  );

  cpu_serial_alu #(.WIDTH(16), .NPC(1)) u_dut1 (
    .clock_i(clk), .reset_i(rst1), .in_valid_i(iv1), .in_ready_o(ir1),
    .operand1_i(a1), .operand2_i(b1), .carry_in_i(cin1), .operation_i(op1),
    .decimal_mode_i(dec1), .out_valid_o(ov1), .out_ready_i(ordy1), .result_o(r1),
    .carry_out_o(c1), .zero_o(z1), .negative_o(n1), .overflow_o(v1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic for binary, decimal digit-by-digit rules for BCD
  task automatic model(input int w, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic dec, output logic [15:0] r,
                       output logic c, output logic z, output logic n, output logic v);
    int mask, ai, bi, s, cc, res, raw3, am, bm;
    mask = (1 << w) - 1;
    ai = int'(a) & mask;
    bi = int'(b) & mask;
    res = 0; cc = 0; raw3 = 0;
    v = 1'b0;
    case (op)
      OP_AND: res = ai & bi;
      OP_OR:  res = ai | bi;
      OP_EOR: res = ai ^ bi;
      OP_ROR: begin res = (ai >> 1) | (int'(cin) << (w - 1)); cc = ai & 1; end
      OP_ROL: begin res = ((ai << 1) | int'(cin)) & mask; cc = (ai >> (w - 1)) & 1; end
      OP_ADC, OP_SBC: begin
        if (op == OP_SBC) bi = ~bi & mask;
        if (!dec) begin
          s = ai + bi + int'(cin);
          res = s & mask;
          cc = (s >> w) & 1;
          raw3 = (res >> (w - 1)) & 1;
        end else begin
          cc = int'(cin);
          for (int k = 0; k < w / 4; k++) begin
            s = ((ai >> (4 * k)) & 15) + ((bi >> (4 * k)) & 15) + cc;
            raw3 = (s >> 3) & 1;
            if (op == OP_ADC) begin
              if (s > 9) begin s = s + 6; cc = 1; end
              else cc = (s >> 4) & 1;
            end else begin
              cc = (s >> 4) & 1;
              if (cc == 0) s = s + 10;
            end
            res = res | ((s & 15) << (4 * k));
          end
        end
        am = (ai >> (w - 1)) & 1;
        bm = (bi >> (w - 1)) & 1;
        v = (am == bm) && (am != raw3);
      end
      default: res = ai;
    endcase
    r = 16'(res & mask);
    c = cc[0];
    z = (res & mask) == 0;
    n = ((res >> (w - 1)) & 1) == 1;
  endtask

  task automatic drive(input int sel, input logic valid, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic cin, input logic dec);
    if (sel == 0) begin iv0 = valid; op0 = op; a0 = a[7:0]; b0 = b[7:0]; cin0 = cin; dec0 = dec; end
    else          begin iv1 = valid; op1 = op; a1 = a;      b1 = b;      cin1 = cin; dec1 = dec; end
  endtask

  task automatic sample(input int sel, output logic [15:0] r, output logic c, output logic z,
                        output logic n, output logic v, output logic ir, output logic ov);
    if (sel == 0) begin r = {8'h00, r0}; c = c0; z = z0; n = n0; v = v0; ir = ir0; ov = ov0; end
    else          begin r = r1;          c = c1; z = z1; n = n1; v = v1; ir = ir1; ov = ov1; end
  endtask

  task automatic set_ordy(input int sel, input logic val);
    if (sel == 0) ordy0 = val; else ordy1 = val;
  endtask

  // Latency = rising edges from the accept edge to the first edge that sees out_valid
  task automatic transact(input int sel, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic dec,
                          output logic [15:0] r, output logic c, output logic z,
                          output logic n, output logic v, output int lat);
    logic ir, ov;
    @(negedge clk);
    sample(sel, r, c, z, n, v, ir, ov);
    chk("in_ready_before_req", {31'd0, ir}, 32'd1);
    drive(sel, 1'b1, op, a, b, cin, dec);
    @(posedge clk); #1;
    drive(sel, 1'b0, op, a, b, cin, dec);
    lat = 1;
    sample(sel, r, c, z, n, v, ir, ov);
    while (!ov && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      sample(sel, r, c, z, n, v, ir, ov);
    end
    @(negedge clk);
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
  endtask

  typedef struct {
    int          sel;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        cin, dec;
    logic [15:0] r;
    logic        c, z, n, v;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] r, er, a, b;
    logic c, z, n, v, ec, ez, en, ev, ir, ov, cin, dec;
    logic [2:0] op;
    int lat, elat, sel, w;

    rst0 = 1; rst1 = 1; ordy0 = 0; ordy1 = 0;
    drive(0, 1'b0, OP_COPY, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, OP_COPY, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, r, c, z, n, v, ir, ov);
      chk("reset_in_ready", {31'd0, ir}, 32'd1);
      chk("reset_out_valid", {31'd0, ov}, 32'd0);
      chk("reset_result", {16'd0, r}, 32'd0);
      chk("reset_flags", {28'd0, c, z, n, v}, 32'd0);
    end
    @(negedge clk);
    rst0 = 0; rst1 = 0;

    //                sel op      a        b        cin   dec   r        c     z     n     v     lat
    vecs.push_back('{0, OP_ADC, 16'h58,   16'h46,   1'b1, 1'b1, 16'h05,   1'b1, 1'b0, 1'b0, 1'b1, 2});
    vecs.push_back('{0, OP_SBC, 16'h46,   16'h12,   1'b1, 1'b1, 16'h34,   1'b1, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{0, OP_SBC, 16'h12,   16'h21,   1'b1, 1'b1, 16'h91,   1'b0, 1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{0, OP_ADC, 16'h7F,   16'h01,   1'b0, 1'b0, 16'h80,   1'b0, 1'b0, 1'b1, 1'b1, 2});
    vecs.push_back('{1, OP_ADC, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 5});
    vecs.push_back('{0, OP_ROR, 16'h01,   16'h00,   1'b1, 1'b0, 16'h80,   1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{0, OP_AND, 16'hF0,   16'h3C,   1'b1, 1'b0, 16'h30,   1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{0, OP_OR,  16'h00,   16'h00,   1'b1, 1'b0, 16'h00,   1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{0, OP_EOR, 16'hA5,   16'hFF,   1'b0, 1'b0, 16'h5A,   1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{0, OP_COPY,16'h81,   16'h55,   1'b1, 1'b1, 16'h81,   1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{0, OP_ROL, 16'h81,   16'h00,   1'b0, 1'b0, 16'h02,   1'b1, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{1, OP_SBC, 16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0, 1'b0, 1'b0, 5});
    vecs.push_back('{1, OP_ADC, 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 5});

    foreach (vecs[i]) begin
      transact(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].dec,
               r, c, z, n, v, lat);
      chk($sformatf("vec%0d_result", i), {16'd0, r}, {16'd0, vecs[i].r});
      chk($sformatf("vec%0d_flags_czNv", i), {28'd0, c, z, n, v},
          {28'd0, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    for (int i = 0; i < 240; i++) begin
      sel = i % 2;
      w   = (sel == 0) ? 8 : 16;
      op  = 3'($urandom_range(0, 7));
      a   = 16'($urandom);
      b   = 16'($urandom);
      if (w == 8) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
      cin = 1'($urandom);
      dec = 1'($urandom);
      model(w, op, a, b, cin, dec, er, ec, ez, en, ev);
      elat = (op == OP_ADC || op == OP_SBC) ? ((sel == 0) ? 2 : 5) : 1;
      transact(sel, op, a, b, cin, dec, r, c, z, n, v, lat);
      chk($sformatf("rand%0d_result op=%0d a=%h b=%h c=%0d d=%0d", i, op, a, b, cin, dec),
          {16'd0, r}, {16'd0, er});
      chk($sformatf("rand%0d_flags_czNv", i), {28'd0, c, z, n, v}, {28'd0, ec, ez, en, ev});
      chk($sformatf("rand%0d_latency", i), lat, elat);
    end

    // Backpressure on DUT0: result must hold while a second request is offered and ignored
    @(negedge clk);
    drive(0, 1'b1, OP_ADC, 16'h12, 16'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, OP_ADC, 16'h12, 16'h34, 1'b0, 1'b0);
    lat = 1;
    while (!ov0 && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", lat, 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(0, 1'b1, OP_AND, 16'hFF, 16'hFF, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_result", k), {24'd0, r0}, 32'h46);
      chk($sformatf("bp%0d_out_valid_in_ready", k), {30'd0, ov0, ir0}, 32'b10);
    end
    @(negedge clk);
    drive(0, 1'b0, OP_AND, 16'hFF, 16'hFF, 1'b1, 1'b0);
    ordy0 = 1;
    @(posedge clk); #1;
    ordy0 = 0;
    chk("bp_release_in_ready", {31'd0, ir0}, 32'd1);
    chk("bp_release_out_valid", {31'd0, ov0}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_second_req_ignored", {31'd0, ov0}, 32'd0);

    // Reset mid-RUN on DUT1 after leaving a nonzero result behind
    transact(1, OP_ADC, 16'h1234, 16'h1111, 1'b0, 1'b0, r, c, z, n, v, lat);
    chk("pre_reset_result", {16'd0, r}, 32'h2345);
    @(negedge clk);
    drive(1, 1'b1, OP_ADC, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, OP_ADC, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("mid_run_busy", {30'd0, ir1, ov1}, 32'd0);
    @(negedge clk);
    rst1 = 1;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, ir1}, 32'd1);
    chk("abort_out_valid", {31'd0, ov1}, 32'd0);
    chk("abort_result", {16'd0, r1}, 32'd0);
    chk("abort_flags", {28'd0, c1, z1, n1, v1}, 32'd0);
    @(negedge clk);
    rst1 = 0;
    transact(1, OP_ADC, 16'h0199, 16'h0001, 1'b0, 1'b1, r, c, z, n, v, lat);
    chk("post_reset_result", {16'd0, r}, 32'h0200);
    chk("post_reset_flags_czNv", {28'd0, c, z, n, v}, 32'd0);
    chk("post_reset_latency", lat, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
